chan_scan_select: RTL and testbench

//  Parametrised N-channel registered selector for the lab boards. Picks one W-bit channel

---
 rtl/chan_scan_pkg.sv | 38 +++
 rtl/scan_rr_next.sv | 34 +++
 rtl/chan_scan_select.sv | 163 ++++++++++++++++
 tb/tb_chan_scan_select.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_scan_pkg.sv
// chan_scan_pkg: shared types and the datapath op helper for chan_scan_select.
//   op_e     : channel operation (pass / invert / AND next / OR next)
//   state_e  : selector mode (manual index or round-robin scan)
//   apply_op : op evaluated on operands zero-extended to OP_MAX_W bits;
//              callers truncate back to their channel width (W <= OP_MAX_W).
package chan_scan_pkg;

    localparam int unsigned OP_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_INV  = 2'd1,
        OP_AND  = 2'd2,
        OP_OR   = 2'd3
    } op_e;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_e;

    function automatic logic [OP_MAX_W-1:0] apply_op(
        input op_e                 op,
        input logic [OP_MAX_W-1:0] x,
        input logic [OP_MAX_W-1:0] y
    );
        logic [OP_MAX_W-1:0] r;
        case (op)
            OP_PASS: r = x;
            OP_INV:  r = ~x;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scan_rr_next.sv
// scan_rr_next: combinational circular search for the next enabled channel.
// Used only when CHAN_MASK_EN is defined.
//   cur  : starting index (search begins at cur+1 and wraps)
//   mask : channel enable bits
//   next : first enabled index after cur, circularly (cur itself if it is
//          the only enabled channel; cur unchanged when mask is zero)
//   any  : at least one channel is enabled
module scan_rr_next #(
    parameter  int unsigned NCH   = 4,
    localparam int unsigned SEL_W = $clog2(NCH)
) (
    input  logic [SEL_W-1:0] cur,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] next,
    output logic             any
);

    logic found_c;

    // Offsets 1..NCH cover every other channel, then cur itself last.
    always_comb begin
        next    = cur;
        found_c = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            if (!found_c && mask[(32'(cur) + k) % NCH]) begin
                next    = SEL_W'((32'(cur) + k) % NCH);
                found_c = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/chan_scan_select.sv
// chan_scan_select: N-channel registered selector with manual or round-robin
// scan selection, a per-sample op, and a valid/ready output register.
// Optional feature macro: CHAN_MASK_EN (adds chan_mask channel enables).
//   clk, rst_n       : clock, asynchronous active-low reset
//   din              : packed channels, channel i = din[i*W +: W]
//   scan_en          : 1 = scan mode, 0 = manual mode
//   sel, sample_req  : manual channel index and one-cycle sample request
//   op               : 0 PASS, 1 INV, 2 AND next, 3 OR next
//   chan_mask        : channel enables (CHAN_MASK_EN only)
//   out_data, out_ch : registered result and its source channel
//   out_valid/ready  : output handshake
//   overflow         : sticky, a sample was dropped while output stalled
//   sample_cnt       : accepted sample count, wraps
module chan_scan_select
    import chan_scan_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned W     = 9,
    parameter  int unsigned DWELL = 16,
    localparam int unsigned SEL_W = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*W-1:0]   din,
    input  logic               scan_en,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sample_req,
    input  logic [1:0]         op,
`ifdef CHAN_MASK_EN
    input  logic [NCH-1:0]     chan_mask,
`endif
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow,
    output logic [15:0]        sample_cnt
);

    localparam int unsigned       CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, ovf_q;
    logic [W-1:0]     data_q;
    logic [SEL_W-1:0] ch_q;
    logic [15:0]      scnt_q;

    logic [NCH-1:0]   mask_c;
    logic             any_c;
    logic [SEL_W-1:0] cur_c, next_c;
    logic             sel_ok_c, evt_c, accept_c;
    logic [SEL_W-1:0] src_c, nxt_c;
    logic [W-1:0]     chan_c [NCH];
    logic [W-1:0]     res_c;

    // In manual mode the search starts from the last channel, so next_c is
    // the lowest enabled channel: the scan entry point.
    assign cur_c = (state_q == S_SCAN) ? ptr_q : CH_LAST;

`ifdef CHAN_MASK_EN
    assign mask_c = chan_mask;

    scan_rr_next #(.NCH(NCH)) u_rr_next (
        .cur  (cur_c),
        .mask (mask_c),
        .next (next_c),
        .any  (any_c)
    );
`else
    assign mask_c = '1;
    assign any_c  = 1'b1;
    assign next_c = (cur_c == CH_LAST) ? '0 : cur_c + SEL_W'(1);
`endif

    assign sel_ok_c = (32'(sel) < NCH) && mask_c[sel];
    assign accept_c = valid_q && out_ready;

    // Mode FSM, scan pointer/dwell counter and sample event generation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        evt_c   = 1'b0;
        src_c   = ptr_q;
        case (state_q)
            S_MANUAL: begin
                src_c = sel;
                evt_c = sample_req && sel_ok_c;
                if (scan_en) begin
                    state_d = S_SCAN;
                    ptr_d   = next_c;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                evt_c = any_c && (cnt_q == CNT_LAST);
                if (!scan_en) begin
                    state_d = S_MANUAL;
                    cnt_d   = '0;
                end else if (!any_c) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    ptr_d = next_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_MANUAL;
        endcase
    end

    // Datapath: source channel and its unmasked circular neighbour.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            chan_c[i] = din[i*W +: W];
        end
    end

    assign nxt_c = (src_c == CH_LAST) ? '0 : src_c + SEL_W'(1);
    assign res_c = W'(apply_op(op_e'(op), OP_MAX_W'(chan_c[src_c]), OP_MAX_W'(chan_c[nxt_c])));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MANUAL;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ovf_q   <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            // A stalled output keeps its sample; the new one is lost.
            if (evt_c && (!valid_q || out_ready)) begin
                valid_q <= 1'b1;
                data_q  <= res_c;
                ch_q    <= src_c;
            end else if (evt_c) begin
                ovf_q   <= 1'b1;
            end else if (accept_c) begin
                valid_q <= 1'b0;
            end
            if (accept_c) begin
                scnt_q <= scnt_q + 16'd1;
            end
        end
    end

    assign out_data   = data_q;
    assign out_ch     = ch_q;
    assign out_valid  = valid_q;
    assign overflow   = ovf_q;
    assign sample_cnt = scnt_q;

endmodule

// File: tb/tb_chan_scan_select.sv
// tb_chan_scan_select: scoreboard bench for chan_scan_select (NCH=4, W=9,
// DWELL=4). Masked-channel scenario runs when CHAN_MASK_EN is defined.
module tb_chan_scan_select;

    localparam int unsigned NCH   = 4;
    localparam int unsigned W     = 9;
    localparam int unsigned DWELL = 4;
    localparam int unsigned SEL_W = 2;

    typedef struct {
        logic [W-1:0]     data;
        logic [SEL_W-1:0] ch;
        int               cyc;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NCH*W-1:0]   din;
    logic               scan_en;
    logic [SEL_W-1:0]   sel;
    logic               sample_req;
    logic [1:0]         op;
`ifdef CHAN_MASK_EN
    logic [NCH-1:0]     chan_mask;
`endif
    logic [W-1:0]       out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic [15:0]        sample_cnt;

    exp_t         sb_q[$];
    int           n_vec;
    int           n_err;
    logic [15:0]  exp_cnt;

    chan_scan_select #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .scan_en    (scan_en),
        .sel        (sel),
        .sample_req (sample_req),
        .op         (op),
`ifdef CHAN_MASK_EN
        .chan_mask  (chan_mask),
`endif
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (o)
            2'd0:    return x;
            2'd1:    return ~x;
            2'd2:    return x & y;
            default: return x | y;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        #1;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 000", out_data); end
        if (out_ch !== '0) begin n_err++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (sample_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual_pass();
        exp_t e;
        @(negedge clk);
        din = {9'h000, 9'h0A5, 9'h000, 9'h000};
        sel = 2'd2; op = 2'd0; out_ready = 1'b1; sample_req = 1'b1;
        e.data = 9'h0A5; e.ch = 2'd2; e.cyc = 1;
        sb_q.push_back(e);
        tick();
        sample_req = 1'b0;
        e = sb_q.pop_front();
        n_vec += 4;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid got %b want 1", out_valid); end
        if (out_data !== e.data) begin n_err++; $display("FAIL pass_data got %h want %h", out_data, e.data); end
        if (out_ch !== e.ch) begin n_err++; $display("FAIL pass_ch got %0d want %0d", out_ch, e.ch); end
        if (sample_cnt !== 16'd0) begin n_err++; $display("FAIL pass_cnt_pre got %0d want 0", sample_cnt); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL pass_drain got %b want 0", out_valid); end
        if (sample_cnt !== exp_cnt) begin n_err++; $display("FAIL pass_cnt got %0d want %0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_ops();
        logic [NCH*W-1:0] vdin [4];
        logic [SEL_W-1:0] vsel [4];
        logic [1:0]       vop  [4];
        logic [W-1:0]     vexp [4];
        exp_t e;
        vdin[0] = {9'h000, 9'h000, 9'h000, 9'h00F}; vsel[0] = 2'd0; vop[0] = 2'd1; vexp[0] = 9'h1F0;
        vdin[1] = {9'h1F0, 9'h000, 9'h000, 9'h0FF}; vsel[1] = 2'd3; vop[1] = 2'd2; vexp[1] = 9'h0F0;
        vdin[2] = {9'h000, 9'h0F0, 9'h101, 9'h000}; vsel[2] = 2'd1; vop[2] = 2'd3; vexp[2] = 9'h1F1;
        vdin[3] = {9'h155, 9'h1FF, 9'h000, 9'h000}; vsel[3] = 2'd2; vop[3] = 2'd2; vexp[3] = 9'h155;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            din = vdin[v]; sel = vsel[v]; op = vop[v]; sample_req = 1'b1;
            e.data = vexp[v]; e.ch = vsel[v]; e.cyc = 1;
            sb_q.push_back(e);
            tick();
            sample_req = 1'b0;
            e = sb_q.pop_front();
            n_vec += 3;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL op%0d_valid got %b want 1", v, out_valid); end
            if (out_data !== e.data) begin n_err++; $display("FAIL op%0d_data got %h want %h", v, out_data, e.data); end
            if (out_ch !== e.ch) begin n_err++; $display("FAIL op%0d_ch got %0d want %0d", v, out_ch, e.ch); end
            exp_cnt = exp_cnt + 16'd1;
        end
        tick();
        n_vec++;
        if (sample_cnt !== exp_cnt) begin n_err++; $display("FAIL ops_cnt got %0d want %0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_scan();
        logic [W-1:0] cv [NCH];
        exp_t e;
        cv[0] = 9'h001; cv[1] = 9'h010; cv[2] = 9'h100; cv[3] = 9'h003;
        @(negedge clk);
        din = {cv[3], cv[2], cv[1], cv[0]};
        op = 2'd3; out_ready = 1'b1; sample_req = 1'b0; scan_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e.ch   = SEL_W'(i % NCH);
            e.data = ref_op(2'd3, cv[i % NCH], cv[(i + 1) % NCH]);
            e.cyc  = int'(DWELL) * (i + 1) + 1;
            sb_q.push_back(e);
            exp_cnt = exp_cnt + 16'd1;
        end
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL scan_extra sample ch %0d at cycle %0d, none expected", out_ch, k);
                end else begin
                    e = sb_q.pop_front();
                    n_vec += 3;
                    if (out_ch !== e.ch) begin n_err++; $display("FAIL scan_ch got %0d want %0d", out_ch, e.ch); end
                    if (out_data !== e.data) begin n_err++; $display("FAIL scan_data got %h want %h", out_data, e.data); end
                    if (k != e.cyc) begin n_err++; $display("FAIL scan_cycle got %0d want %0d", k, e.cyc); end
                end
            end
        end
        n_vec += 2;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL scan_missing got %0d left want 0", sb_q.size()); sb_q.delete(); end
        if (sample_cnt !== exp_cnt) begin n_err++; $display("FAIL scan_cnt got %0d want %0d", sample_cnt, exp_cnt); end
        scan_en = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        apply_reset();
        @(negedge clk);
        din = {9'h003, 9'h100, 9'h010, 9'h001};
        op = 2'd0; out_ready = 1'b0; scan_en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 8) begin
                n_vec += 3;
                if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_hold_valid got %b want 1", out_valid); end
                if (out_ch !== 2'd0) begin n_err++; $display("FAIL ovf_hold_ch got %0d want 0", out_ch); end
                if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
            if (k == 9) begin
                n_vec += 3;
                if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow); end
                if (out_ch !== 2'd0) begin n_err++; $display("FAIL ovf_old_ch got %0d want 0", out_ch); end
                if (out_data !== 9'h001) begin n_err++; $display("FAIL ovf_old_data got %h want 001", out_data); end
            end
            if (k == 12) out_ready = 1'b1;
            if (k == 13) begin
                n_vec += 5;
                if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_new_valid got %b want 1", out_valid); end
                if (out_ch !== 2'd2) begin n_err++; $display("FAIL ovf_new_ch got %0d want 2", out_ch); end
                if (out_data !== 9'h100) begin n_err++; $display("FAIL ovf_new_data got %h want 100", out_data); end
                if (sample_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_cnt got %0d want 1", sample_cnt); end
                if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
            end
            if (k == 14) begin
                n_vec += 2;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %b want 0", out_valid); end
                if (sample_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_cnt2 got %0d want 2", sample_cnt); end
            end
        end
        scan_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_midscan();
        exp_t e;
        @(negedge clk);
        din = {9'h003, 9'h100, 9'h010, 9'h001};
        op = 2'd0; out_ready = 1'b0; scan_en = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec += 5;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        if (out_data !== '0) begin n_err++; $display("FAIL mid_rst_data got %h want 000", out_data); end
        if (out_ch !== '0) begin n_err++; $display("FAIL mid_rst_ch got %0d want 0", out_ch); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b want 0", overflow); end
        if (sample_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", sample_cnt); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        e.data = 9'h001; e.ch = 2'd0; e.cyc = int'(DWELL) + 1;
        sb_q.push_back(e);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL mid_extra sample ch %0d at cycle %0d, none expected", out_ch, k);
                end else begin
                    e = sb_q.pop_front();
                    n_vec += 3;
                    if (out_ch !== e.ch) begin n_err++; $display("FAIL mid_restart_ch got %0d want %0d", out_ch, e.ch); end
                    if (out_data !== e.data) begin n_err++; $display("FAIL mid_restart_data got %h want %h", out_data, e.data); end
                    if (k != e.cyc) begin n_err++; $display("FAIL mid_restart_cycle got %0d want %0d", k, e.cyc); end
                end
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL mid_missing got %0d left want 0", sb_q.size()); sb_q.delete(); end
        scan_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        @(negedge clk);
        din = {9'h003, 9'h100, 9'h010, 9'h001};
        op = 2'd0; out_ready = 1'b1; scan_en = 1'b0;
        sel = 2'd1; sample_req = 1'b1;
        e.data = 9'h010; e.ch = 2'd1; e.cyc = 1;
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        n_vec += 2;
        if (out_valid !== 1'b1 || out_ch !== e.ch) begin n_err++; $display("FAIL b2b_first_ch got %b/%0d want 1/%0d", out_valid, out_ch, e.ch); end
        if (out_data !== e.data) begin n_err++; $display("FAIL b2b_first_data got %h want %h", out_data, e.data); end
        sel = 2'd2;
        e.data = 9'h100; e.ch = 2'd2; e.cyc = 2;
        sb_q.push_back(e);
        tick();
        sample_req = 1'b0;
        e = sb_q.pop_front();
        n_vec += 4;
        if (out_valid !== 1'b1 || out_ch !== e.ch) begin n_err++; $display("FAIL b2b_second_ch got %b/%0d want 1/%0d", out_valid, out_ch, e.ch); end
        if (out_data !== e.data) begin n_err++; $display("FAIL b2b_second_data got %h want %h", out_data, e.data); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", overflow); end
        if (sample_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_cnt1 got %0d want 1", sample_cnt); end
        tick();
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        if (sample_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_cnt2 got %0d want 2", sample_cnt); end
    endtask

`ifdef CHAN_MASK_EN
    task automatic test_mask();
        exp_t e;
        int   seen;
        apply_reset();
        @(negedge clk);
        din = {9'h003, 9'h100, 9'h010, 9'h001};
        op = 2'd0; out_ready = 1'b1; chan_mask = 4'b1010; scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.ch   = (i % 2 == 0) ? 2'd1 : 2'd3;
            e.data = (i % 2 == 0) ? 9'h010 : 9'h003;
            e.cyc  = int'(DWELL) * (i + 1) + 1;
            sb_q.push_back(e);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL mask_extra sample ch %0d at cycle %0d, none expected", out_ch, k);
                end else begin
                    e = sb_q.pop_front();
                    n_vec += 3;
                    if (out_ch !== e.ch) begin n_err++; $display("FAIL mask_ch got %0d want %0d", out_ch, e.ch); end
                    if (out_data !== e.data) begin n_err++; $display("FAIL mask_data got %h want %h", out_data, e.data); end
                    if (k != e.cyc) begin n_err++; $display("FAIL mask_cycle got %0d want %0d", k, e.cyc); end
                end
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin n_err++; $display("FAIL mask_missing got %0d left want 0", sb_q.size()); sb_q.delete(); end
        scan_en = 1'b0;
        tick();
        chan_mask = 4'b0000; scan_en = 1'b1;
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL mask_zero got %0d samples want 0", seen); end
        scan_en = 1'b0;
        chan_mask = 4'b1010;
        tick();
        sel = 2'd0; sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mask_sel_off got %b want 0", out_valid); end
        sel = 2'd1; sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1) begin n_err++; $display("FAIL mask_sel_on got %b/%0d want 1/1", out_valid, out_ch); end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0; din = '0; scan_en = 1'b0; sel = '0; sample_req = 1'b0;
        op = 2'd0; out_ready = 1'b1;
`ifdef CHAN_MASK_EN
        chan_mask = 4'b1111;
`endif
        n_vec = 0; n_err = 0; exp_cnt = '0;
        test_reset();
        test_manual_pass();
        test_ops();
        test_scan();
        test_overflow();
        test_reset_midscan();
        test_back_to_back();
`ifdef CHAN_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
